// File: rtl/pc_predict_unit.sv
// Fetch PC generator with a direct-mapped BTB and per-entry saturating direction
// counters; redirects on predicted-taken hits and recovers on MEM-stage mispredicts.
module pc_predict_unit #(
  parameter int                WORD_W   = 32,
  parameter logic [WORD_W-1:0] PC_INIT  = '0,
  parameter int                ENTRIES  = 16,
  parameter int                CTR_BITS = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pcen,
  output logic [WORD_W-1:0] cpc,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [WORD_W-1:0] res_pc,
  input  logic              res_is_branch,
  input  logic              res_taken,
  input  logic [WORD_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [WORD_W-1:0] res_pred_target,
  output logic              flush,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // BTB storage: valid and counters are control state, tag/target are plain data
  logic                valid_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  logic [WORD_W-1:0]   tgt_q   [ENTRIES];

  logic [WORD_W-1:0] cpc_q, cpc_d;
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             mispredict;

  logic                upd_ctrl;
  logic                upd_data;
  logic [CTR_BITS-1:0] upd_ctr;

  // ---- fetch-side lookup (combinational on the current PC)
  assign f_idx = cpc_q[IDX_W+1:2];
  assign f_tag = cpc_q[WORD_W-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_taken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
  assign pred_target = f_hit ? tgt_q[f_idx] : '0;

  // ---- resolution-side lookup and misprediction detect
  assign r_idx = res_pc[IDX_W+1:2];
  assign r_tag = res_pc[WORD_W-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign mispredict = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign flush = mispredict;

  // Recovery outranks the hazard-unit stall so a flushed pipe never refetches stale PCs
  always_comb begin
    cpc_d = cpc_q;
    if (mispredict) begin
      cpc_d = res_taken ? res_target : res_pc + PC_STEP;
    end else if (pcen) begin
      cpc_d = pred_taken ? pred_target : cpc_q + PC_STEP;
    end
  end

  // Not-taken branches that miss never allocate; they would only evict useful entries
  always_comb begin
    upd_ctrl = 1'b0;
    upd_data = 1'b0;
    upd_ctr  = ctr_q[r_idx];
    if (res_valid) begin
      if (!res_is_branch) begin
        upd_ctrl = 1'b1;
        upd_data = 1'b1;
        upd_ctr  = CTR_MAX;
      end else if (res_taken) begin
        upd_ctrl = 1'b1;
        upd_data = 1'b1;
        upd_ctr  = r_hit ? ctr_inc(ctr_q[r_idx]) : CTR_WT;
      end else if (r_hit) begin
        upd_ctrl = 1'b1;
        upd_ctr  = ctr_dec(ctr_q[r_idx]);
      end
    end
  end

  always_comb begin
    branch_cnt_d  = res_valid  ? cnt_sat_inc(branch_cnt_q)  : branch_cnt_q;
    mispred_cnt_d = mispredict ? cnt_sat_inc(mispred_cnt_q) : mispred_cnt_q;
  end

  // ---- state update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cpc_q         <= PC_INIT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else begin
      cpc_q         <= cpc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (upd_ctrl) begin
        valid_q[r_idx] <= 1'b1;
        ctr_q[r_idx]   <= upd_ctr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (upd_data) begin
      tag_q[r_idx] <= r_tag;
      tgt_q[r_idx] <= res_target;
    end
  end

  assign cpc              = cpc_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised next-generation fetch PC unit for the pipelined MIPS core. It replaces the fixed "cpc+4 / resolve late" next-PC logic with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. Fetch redirects on predicted-taken hits. Resolution arrives from the MEM stage; on a misprediction the unit issues a flush and restarts fetch at the correct PC. It sits between the hazard unit (pcen) and instruction memory (cpc drives imemaddr).

Parameters:
PC_INIT, 32'h0, reset fetch address
ENTRIES, 16, BTB entries; power of two, >= 2; IDX_W = log2(ENTRIES)
CTR_BITS, 2, direction counter width; >= 1
WORD_W, 32, address width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
pcen  in  1  advance fetch this cycle (ihit & ~dhit & ~stall)
cpc  out  WORD_W  current fetch PC, registered
pred_taken  out  1  combinational: BTB hit on cpc && counter MSB == 1
pred_target  out  WORD_W  combinational: BTB target for cpc; 0 when no hit
res_valid  in  1  one-cycle pulse: a control-transfer instruction resolved in MEM
res_pc  in  WORD_W  PC of the resolving instruction
res_is_branch  in  1  1 = conditional branch (BEQ/BNE); 0 = J/JAL/JR
res_taken  in  1  actual direction (forced 1 for jumps)
res_target  in  WORD_W  actual target address
res_pred_taken  in  1  prediction carried down the pipe with the instruction
res_pred_target  in  WORD_W  predicted target carried down the pipe
flush  out  1  combinational misprediction: flush IF/ID, ID/EX, EX/MEM
branch_count  out  32  resolved control transfers, saturating
mispredict_count  out  32  mispredictions, saturating

Behaviour:
- Reset (async, nRST=0):
  - cpc = PC_INIT.
  - All valid bits = 0.
  - All counters = weakly-not-taken, 2^(CTR_BITS-1)-1. For CTR_BITS=1 this value is 0.
  - Perf counters = 0.
  - Outputs: pred_taken = 0; flush = 0 while res_valid = 0.
- Indexing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[WORD_W-1:IDX_W+2].
  - hit = valid[idx] && tag match.
- Misprediction: mispredict = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)). flush = mispredict in the same cycle.
- Next cpc, by priority:
  1. mispredict: cpc <= res_taken ? res_target : res_pc+4. Applies regardless of pcen.
  2. pcen: cpc <= pred_taken ? pred_target : cpc+4.
  3. Otherwise hold.
- All PC arithmetic is modulo 2^WORD_W; 0xFFFFFFFC+4 = 0.
- BTB update on the clock edge when res_valid=1, at idx(res_pc):
  - Jump (res_is_branch=0): write valid=1, tag, target=res_target, counter = all ones.
  - Branch, taken, hit: counter saturating increment; target = res_target.
  - Branch, taken, miss: allocate (valid, tag, target); counter = 2^(CTR_BITS-1), weakly taken.
  - Branch, not taken, hit: counter saturating decrement; entry stays valid.
  - Branch, not taken, miss: no change, no allocation.
- Same-cycle lookup and update of the same index: lookup uses pre-edge contents. The write is visible the next cycle.
- Tag conflict: allocation overwrites the old entry unconditionally.
- Perf counters:
  - branch_count += 1 on each res_valid.
  - mispredict_count += 1 on each mispredict.
  - Both hold at 0xFFFFFFFF.
- res_valid is asserted at most once per resolving instruction. The unit does not deduplicate stalled MEM-stage pulses; the hazard unit gates them.
- Reset mid-operation: immediate return to reset state; any pending redirect is discarded.
- Latency:
  - Prediction is zero-cycle (combinational on cpc).
  - Redirect takes one edge.
  - BTB training is visible one cycle after res_valid.

Test Plan:
1. Reset: nRST=0 with PC_INIT=0x100, then release; 3 cycles with pcen=1 -> cpc = 0x100, 0x104, 0x108; pred_taken=0 throughout.
2. Cold taken branch: res_valid with res_pc=0x10, res_is_branch=1, res_taken=1, res_target=0x40, res_pred_taken=0 -> flush=1 that cycle. Next cpc=0x40, branch_count=1, mispredict_count=1. Later, cpc=0x10 gives pred_taken=1 and pred_target=0x40.
3. Counter hysteresis: after test 2, resolve 0x10 not-taken once -> counter 1, pred_taken=0 at 0x10. Resolve taken twice -> counter 3. One not-taken -> counter 2, still predicts taken.
4. Jump and aliasing: JR at 0x20 to 0x200 -> counter = 3. With ENTRIES=16, a taken branch at 0x60 (same idx, different tag) overwrites the entry -> cpc=0x20 then gives pred_taken=0.
5. Redirect during stall: pcen=0 and mispredict with res_taken=0, res_pc=0x80 -> cpc=0x84 next edge. When mispredict and pcen are both 1, the redirect wins.
6. Wrap and saturation: cpc=0xFFFFFFFC with pcen=1 -> cpc=0. Force mispredict_count to 0xFFFFFFFF, inject one mispredict -> count holds at 0xFFFFFFFF.
